// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are served combinationally in IDLE. A miss latches the address and
// moves to FILL, which requests the word from the memory controller until
// iwait drops. Saturating hit and miss counters are kept for performance checks.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state, next_state;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tag_mem  [SETS];
  logic [31:0]        data_mem [SETS];
  logic [31:0]        latched_addr;

  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic               lookup_match;
  logic               accept;
  logic               hit, miss, fill_done;

  assign req_tag  = imemaddr[31:IDX_W+2];
  assign req_idx  = imemaddr[IDX_W+1:2];
  assign fill_tag = latched_addr[31:IDX_W+2];
  assign fill_idx = latched_addr[IDX_W+1:2];

  // A request is only looked up in IDLE and while no flush is in progress,
  // so a flushing cycle neither hits, misses, nor moves the counters.
  assign lookup_match = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept       = (state == IDLE) && imemREN && !flush;
  assign hit          = accept && lookup_match;
  assign miss         = accept && !lookup_match;
  assign fill_done    = (state == FILL) && !iwait;

  // Next-state and output decode; outputs default to idle values first
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = latched_addr;
    case (state)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = data_mem[req_idx];
        end else if (miss) begin
          next_state = FILL;
        end
      end
      FILL: begin
        iREN = 1'b1;
        if (!iwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset drops out of FILL immediately, which also drops iREN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Capture the missing address; it stays fixed for the whole fill
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     latched_addr <= 32'h0;
    else if (miss) latched_addr <= imemaddr;
  end

  // Valid bits: flush wins over a same-cycle fill so the frame ends invalid
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          valid <= '0;
    else if (flush)     valid <= '0;
    else if (fill_done) valid[fill_idx] <= 1'b1;
  end

  // Tag and data arrays need no reset; they are ignored while valid is low
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= iload;
    end
  end

  // Saturating hit counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          hit_count <= 32'h0;
    else if (hit && hit_count != '1)    hit_count <= hit_count + 32'd1;
  end

  // Saturating miss counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          miss_count <= 32'h0;
    else if (miss && miss_count != '1)  miss_count <= miss_count + 32'd1;
  end

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: expected hit data is queued by the
// stimulus and popped by a monitor on every cycle the cache raises ihit.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  logic [31:0] exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  icache_direct #(.SETS(16), .IDX_W(4), .TAG_W(26)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .flush     (flush),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One clock cycle with the given inputs; returns just after the edge
  task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                               input logic fl, input logic wt,
                               input logic [31:0] ld);
    imemREN  = ren;
    imemaddr = addr;
    flush    = fl;
    iwait    = wt;
    iload    = ld;
    @(posedge CLK);
    #1;
  endtask

  // Miss on addr, hold iwait for nwait cycles, then return data
  task automatic readMiss(input logic [31:0] addr, input int nwait,
                          input logic [31:0] data);
    applyStimulus(1'b1, addr, 1'b0, 1'b1, 32'h0);
    checkOutput("miss_iREN", {31'h0, iREN}, 32'h1);
    checkOutput("miss_iaddr", iaddr, addr);
    for (int i = 0; i < nwait; i++) begin
      applyStimulus(1'b1, addr, 1'b0, 1'b1, 32'hDEADBEEF);
      checkOutput("wait_iREN", {31'h0, iREN}, 32'h1);
    end
    applyStimulus(1'b1, addr, 1'b0, 1'b0, data);
    checkOutput("filled_iREN", {31'h0, iREN}, 32'h0);
  endtask

  // Expect a hit on addr returning data
  task automatic readHit(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back(data);
    applyStimulus(1'b1, addr, 1'b0, 1'b1, 32'h0);
    checkOutput("hit_iREN", {31'h0, iREN}, 32'h0);
  endtask

  // Monitor: every ihit must match the oldest queued expectation
  always @(negedge CLK) begin : monitor
    logic [31:0] exp_data;
    if (nRST && ihit) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_hit: ihit=1 imemload=0x%08h, expected ihit=0", imemload);
      end else begin
        exp_data = exp_q.pop_front();
        checkOutput("hit_data", imemload, exp_data);
      end
    end
  end

  // Hang guard
  initial begin
    #50000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Directed sequence
  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    flush    = 1'b0;
    iwait    = 1'b1;
    iload    = 32'h0;
    #1;
    checkOutput("rst_ihit", {31'h0, ihit}, 32'h0);
    checkOutput("rst_iREN", {31'h0, iREN}, 32'h0);
    checkOutput("rst_iaddr", iaddr, 32'h0);
    checkOutput("rst_imemload", imemload, 32'h0);
    checkOutput("rst_hit_count", hit_count, 32'h0);
    checkOutput("rst_miss_count", miss_count, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Cold miss with three wait cycles, then a hit
    readMiss(32'h40, 3, 32'h8C220004);
    readHit(32'h40, 32'h8C220004);
    checkOutput("t1_miss_count", miss_count, 32'd1);
    checkOutput("t1_hit_count", hit_count, 32'd1);

    // Five back-to-back hits
    for (int i = 0; i < 5; i++) readHit(32'h40, 32'h8C220004);
    checkOutput("t2_hit_count", hit_count, 32'd6);

    // Conflict on index 0
    readMiss(32'h80, 1, 32'h11112222);
    readHit(32'h80, 32'h11112222);
    readMiss(32'h40, 0, 32'h8C220004);
    readHit(32'h40, 32'h8C220004);
    checkOutput("t3_miss_count", miss_count, 32'd3);
    checkOutput("t3_hit_count", hit_count, 32'd8);

    // Address change and request drop during FILL
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b1, 32'h0);
    checkOutput("t4_iREN", {31'h0, iREN}, 32'h1);
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b1, 32'h0);
    checkOutput("t4_iaddr_held", iaddr, 32'h44);
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0, 32'hAAAA0044);
    checkOutput("t4_filled_iREN", {31'h0, iREN}, 32'h0);
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b1, 32'h0);
    checkOutput("t4_miss_count", miss_count, 32'd4);
    readHit(32'h44, 32'hAAAA0044);
    checkOutput("t4_hit_count", hit_count, 32'd9);

    // Flush coinciding with the fill write leaves the frame invalid
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b1, 32'h0);
    applyStimulus(1'b1, 32'h48, 1'b1, 1'b0, 32'h55555555);
    checkOutput("t5_flush_iREN", {31'h0, iREN}, 32'h0);
    checkOutput("t5_flush_miss_count", miss_count, 32'd5);
    readMiss(32'h48, 0, 32'h55555555);
    readHit(32'h48, 32'h55555555);
    checkOutput("t5_miss_count", miss_count, 32'd6);
    checkOutput("t5_hit_count", hit_count, 32'd10);

    // Flush in IDLE: no hit, counters frozen, frame invalidated
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 32'h0);
    checkOutput("t5b_hit_count", hit_count, 32'd10);
    checkOutput("t5b_miss_count", miss_count, 32'd6);
    readMiss(32'h40, 0, 32'h8C220004);
    readHit(32'h40, 32'h8C220004);
    checkOutput("t5b_miss_after", miss_count, 32'd7);

    // Asynchronous reset in the middle of a fill
    applyStimulus(1'b1, 32'h4C, 1'b0, 1'b1, 32'h0);
    checkOutput("t6_iREN_before", {31'h0, iREN}, 32'h1);
    #2;
    nRST    = 1'b0;
    imemREN = 1'b0;
    #1;
    checkOutput("t6_iREN_async", {31'h0, iREN}, 32'h0);
    checkOutput("t6_hit_count", hit_count, 32'h0);
    checkOutput("t6_miss_count", miss_count, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    readMiss(32'h44, 0, 32'hAAAA0044);
    readHit(32'h44, 32'hAAAA0044);
    checkOutput("t6_miss_after", miss_count, 32'd1);
    checkOutput("t6_hit_after", hit_count, 32'd1);

    // Miss counter saturation
    force dut.miss_count = 32'hFFFFFFFE;
    #1;
    release dut.miss_count;
    readMiss(32'h300, 0, 32'h00000300);
    checkOutput("t7_sat_first", miss_count, 32'hFFFFFFFF);
    readMiss(32'h304, 0, 32'h00000304);
    readMiss(32'h308, 0, 32'h00000308);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    checkOutput("t7_sat_hold", miss_count, 32'hFFFFFFFF);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    checkOutput("scoreboard_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache. It is the responder on the datapath's instruction port: it serves imemREN/imemaddr and returns ihit/imemload.
- On a miss it acts as the initiator toward the memory controller's instruction port (iREN/iaddr/iwait/iload).
- It sits between the pipelined datapath and the memory controller. It also keeps hit and miss counters for performance checks.

Parameters:
- SETS, 16, number of one-word frames; must be a power of 2.
- IDX_W, 4, log2(SETS).
- TAG_W, 26, equals 32 - IDX_W - 2.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- imemREN  input  1  datapath instruction read request.
- imemaddr  input  32  datapath instruction address, word aligned.
- ihit  output  1  imemload is valid this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  read request to the memory controller.
- iaddr  output  32  address sent to the memory controller.
- iwait  input  1  memory controller busy; low means iload is valid.
- iload  input  32  word returned by the memory controller.
- flush  input  1  invalidate all frames.
- hit_count  output  32  number of hits, saturating.
- miss_count  output  32  number of misses, saturating.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. The ports are CLK and nRST.
- Address split: tag = imemaddr[31:IDX_W+2], index = imemaddr[IDX_W+1:2]. Bits [1:0] are ignored.
- Storage: per frame, valid (1 bit), tag (TAG_W bits), data (32 bits). Only valid and the counters are reset; tag and data contents are don't-care while valid=0.
- Reset values: all valid=0, state=IDLE, latched address=0, ihit=0, iREN=0, iaddr=0, imemload=0, hit_count=0, miss_count=0.
- FSM has two states: IDLE and FILL.
- IDLE:
  - hit = imemREN & valid[index] & (tag[index] == tag). The hit is combinational: ihit=hit, imemload=data[index] in the same cycle. hit_count increments at the clock edge.
  - On imemREN with no hit: latch imemaddr, increment miss_count, go to FILL. ihit=0 and iREN=0 in this cycle.
  - When imemREN=0: ihit=0, imemload=0, no state change.
- FILL:
  - iREN=1, iaddr = latched address, ihit=0.
  - When iwait=0: write data=iload, tag and valid=1 into the latched index, then go to IDLE.
  - When iwait=1: stay in FILL.
- Miss latency: miss detected in cycle N. iREN is high from N+1. The fill completes in the first cycle M with iwait=0. The hit comes at M+1 if the address is unchanged.
- imemREN dropping or imemaddr changing during FILL: the fill still completes for the latched address and is never abandoned. The new address is evaluated in IDLE afterwards.
- flush:
  - Clears all valid bits at the clock edge; flush has priority over a same-cycle fill write, so the filled frame ends invalid.
  - Flush during FILL does not abort the handshake.
  - While flush=1, ihit is forced to 0 and the counters do not change.
- Counters saturate at 32'hFFFFFFFF and do not wrap.
- Conflict: addresses with the same index and a different tag evict each other. The last fill wins.
- nRST asserted mid-FILL: the cache returns to IDLE with all frames invalid, and iREN drops immediately (asynchronously).
- iwait is ignored in IDLE. iload is sampled only in FILL with iwait=0.

Test Plan:
- Reset, then imemREN=1 with imemaddr=0x00000040 → ihit=0, next cycle iREN=1 with iaddr=0x40. Hold iwait=1 for 3 cycles, then iwait=0 with iload=0x8C220004 → the cycle after, ihit=1, imemload=0x8C220004, miss_count=1, hit_count=1.
- Repeat the read of 0x40 for 5 cycles → ihit=1 every cycle, hit_count=6, iREN stays 0.
- Conflict: read 0x40, then 0x80 (SETS=16, same index 0) → 0x80 misses. After its fill, 0x40 misses again, so miss_count increments twice.
- During FILL for 0x44, change imemaddr to 0x100 and drop imemREN → the fill completes into index 1. Re-reading 0x44 then hits with no iREN.
- Assert flush for one cycle while iwait=0 in FILL → the frame stays invalid, and a re-read of the same address misses.
- Preload miss_count=0xFFFFFFFE by force and cause 3 misses → the count holds at 0xFFFFFFFF.
